// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a single-port
// synchronous-read RAM (ram_en=1 write, ram_en=0 read).
// One command in flight at a time: IDLE -> ISSUE -> (write) IDLE
//                                              -> (read)  WAIT x RD_LAT -> RESP -> IDLE
// Optional per-requester grant counters are compiled in with `define RAM_ARB_PERF_EN.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1   // ram read latency in clocks, 1..4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
`ifdef RAM_ARB_PERF_EN
  input  logic              cnt_clr,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  input  logic [DATA_W-1:0] ram_dataout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Last WAIT count value; the capture happens on the edge that ends that cycle.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_e              state_q;
  logic                last_grant_q;   // id of the most recent grant; reset 1 so req0 wins the first tie
  logic                id_q;           // requester that owns the command in flight
  logic                we_q;
  logic [1:0]          wait_cnt_q;
  logic                ram_en_q;
  logic [ADDR_W-1:0]   ram_address_q;
  logic [DATA_W-1:0]   ram_datain_q;
  logic                rsp0_valid_q;
  logic                rsp1_valid_q;
  logic [DATA_W-1:0]   rsp0_rdata_q;
  logic [DATA_W-1:0]   rsp1_rdata_q;

  logic                any_valid;
  logic                sel_id;
  logic                accept;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  // Round-robin selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it
    // unassigned and infer a latch.
    sel_id    = 1'b0;
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      sel_id = ~last_grant_q;
    end else begin
      sel_id = req1_valid;
    end
  end

  assign accept     = (state_q == ST_IDLE) && any_valid;
  assign req0_ready = accept && !sel_id;
  assign req1_ready = accept &&  sel_id;

  assign cmd_we    = sel_id ? req1_we    : req0_we;
  assign cmd_addr  = sel_id ? req1_addr  : req0_addr;
  assign cmd_wdata = sel_id ? req1_wdata : req0_wdata;

  // Sequencer FSM with registered ram and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      we_q          <= 1'b0;
      wait_cnt_q    <= '0;
      ram_en_q      <= 1'b0;
      ram_address_q <= '0;
      ram_datain_q  <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_rdata_q  <= '0;
      rsp1_rdata_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      ram_en_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            id_q          <= sel_id;
            we_q          <= cmd_we;
            last_grant_q  <= sel_id;
            ram_address_q <= cmd_addr;
            ram_datain_q  <= cmd_wdata;
            ram_en_q      <= cmd_we;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The ram samples address (and data on a write) at the end of this cycle.
          wait_cnt_q <= '0;
          state_q    <= we_q ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            if (id_q) begin
              rsp1_rdata_q <= ram_dataout;
              rsp1_valid_q <= 1'b1;
            end else begin
              rsp0_rdata_q <= ram_dataout;
              rsp0_valid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_address = ram_address_q;
  assign ram_datain  = ram_datain_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_rdata  = rsp0_rdata_q;
  assign rsp1_rdata  = rsp1_rdata_q;

`ifdef RAM_ARB_PERF_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic        grant0;
  logic        grant1;

  assign grant0 = req0_valid && req0_ready;
  assign grant1 = req1_valid && req1_ready;

  // Saturating grant counters; a clear wins over a coincident grant.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (grant0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
      if (grant1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a scoreboard. Requester tasks push the
// expected ram write / read response (with its cycle) on acceptance; a monitor
// pops and compares whenever the DUT shows ram_en or a rsp strobe.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid [2];
  logic              req_we    [2];
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_datain;
  logic [DATA_W-1:0] ram_dataout;
`ifdef RAM_ARB_PERF_EN
  logic              cnt_clr;
  logic [15:0]       grant_cnt0, grant_cnt1;
`endif

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req_valid[0]),
    .req0_we     (req_we[0]),
    .req0_addr   (req_addr[0]),
    .req0_wdata  (req_wdata[0]),
    .req0_ready  (req0_ready),
    .rsp0_valid  (rsp0_valid),
    .rsp0_rdata  (rsp0_rdata),
    .req1_valid  (req_valid[1]),
    .req1_we     (req_we[1]),
    .req1_addr   (req_addr[1]),
    .req1_wdata  (req_wdata[1]),
    .req1_ready  (req1_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_rdata  (rsp1_rdata),
`ifdef RAM_ARB_PERF_EN
    .cnt_clr     (cnt_clr),
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1),
`endif
    .ram_en      (ram_en),
    .ram_address (ram_address),
    .ram_datain  (ram_datain),
    .ram_dataout (ram_dataout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port ram with RD_LAT-cycle synchronous read.
  logic [DATA_W-1:0] mem     [1<<ADDR_W];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  initial for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_en) mem[ram_address] <= ram_datain;
    else        rd_pipe[0]       <= mem[ram_address];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dataout = rd_pipe[RD_LAT-1];

  // Scoreboard state.
  typedef struct {
    int                cyc;
    int                id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t wr_q  [$];
  exp_t rsp_q [$];
  int   grant_log [$];
  int   acc_cyc   [$];
  int   cyc = 0;
  int   last_wait;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every ram write and every read response against the queues.
  always @(negedge clk) begin
    exp_t e;
    int   act_id;
    if (rst === 1'b0) begin
      if (ram_en === 1'b1) begin
        check("wr_pending", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
          check("wr_addr", 32'(ram_address), 32'(e.addr));
          check("wr_data", 32'(ram_datain), 32'(e.data));
        end
      end
      if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
        check("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 0);
        check("rsp_pending", 32'(rsp_q.size() > 0), 1);
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          act_id = (rsp1_valid === 1'b1) ? 1 : 0;
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
          check("rsp_id", 32'(act_id), 32'(e.id));
          check("rsp_data", 32'(act_id == 1 ? rsp1_rdata : rsp0_rdata), 32'(e.data));
        end
      end
    end
  end

  // Issue one command from requester id; d is write data or the expected read data.
  task automatic send(input int id, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] d);
    bit   got = 1'b0;
    int   start;
    exp_t e;
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    req_addr[id]  = addr;
    req_wdata[id] = we ? d : 8'h5A;
    start = cyc;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if ((id == 0 ? req0_ready : req1_ready) === 1'b1) begin
        got = 1'b1;
        last_wait = cyc - start;
        check("ready_excl", 32'(id == 0 ? req1_ready : req0_ready), 0);
        grant_log.push_back(id);
        acc_cyc.push_back(cyc);
        e.id = id; e.addr = addr; e.data = d;
        if (we) begin e.cyc = cyc + 1;          wr_q.push_back(e);  end
        else    begin e.cyc = cyc + 2 + RD_LAT; rsp_q.push_back(e); end
      end
    end
    check($sformatf("accept_p%0d", id), 32'(got), 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // Wait for all expected transactions to appear.
  task automatic drain();
    int n = 0;
    while ((wr_q.size() != 0 || rsp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(wr_q.size() + rsp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Assert reset now (asynchronously), check all outputs, release after two edges.
  task automatic do_reset();
    rst = 1'b1;
    wr_q.delete();
    rsp_q.delete();
    @(negedge clk);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_address", 32'(ram_address), 0);
    check("rst_ram_datain", 32'(ram_datain), 0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
    check("rst_rdata", 32'({rsp0_rdata, rsp1_rdata}), 0);
`ifdef RAM_ARB_PERF_EN
    check("rst_cnt", {grant_cnt0, grant_cnt1}, 0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
`ifdef RAM_ARB_PERF_EN
    cnt_clr = 1'b0;
`endif
    do_reset();

    // Single write right after reset: accepted at once, one ram write cycle.
    send(0, 1'b1, 10'd800, 8'd50);
    check("first_accept_wait", 32'(last_wait), 0);
    drain();
    check("idle_ram_en", 32'(ram_en), 0);
    check("hold_address", 32'(ram_address), 800);
    check("hold_datain", 32'(ram_datain), 50);

    // Write from req1, then reads from both requesters.
    send(1, 1'b1, 10'd900, 8'd60);
    send(0, 1'b0, 10'd800, 8'd50);
    send(1, 1'b0, 10'd900, 8'd60);
    drain();
    check("rdata0_held", 32'(rsp0_rdata), 50);
    check("rdata1_held", 32'(rsp1_rdata), 60);

    // Both requesters contend with reads from reset: strict alternation 0,1,0,1...
    do_reset();
    grant_log.delete();
    fork
      begin repeat (4) send(0, 1'b0, 10'd800, 8'd50); end
      begin repeat (4) send(1, 1'b0, 10'd900, 8'd60); end
    join
    drain();
    check("rr_count", 32'(grant_log.size()), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("rr_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // req1 alone, three writes: accepted every 2 cycles; rdata untouched by writes.
    base = acc_cyc.size();
    send(1, 1'b1, 10'd10, 8'hA1);
    send(1, 1'b1, 10'd11, 8'hA2);
    send(1, 1'b1, 10'd1023, 8'hA3);
    drain();
    for (int i = 0; i < 2; i++)
      check($sformatf("wr_spacing_%0d", i), 32'(acc_cyc[base+i+1] - acc_cyc[base+i]), 2);
    check("rdata0_after_wr", 32'(rsp0_rdata), 50);
    check("rdata1_after_wr", 32'(rsp1_rdata), 60);

    // Reset in the WAIT cycle of a read: no response, then a reissue is served.
    send(1, 1'b0, 10'd900, 8'd60);
    @(posedge clk); #1;
    do_reset();
    repeat (6) @(negedge clk);
    check("no_rsp_after_rst", 32'(rsp1_rdata), 0);
    send(1, 1'b0, 10'd900, 8'd60);
    check("reissue_accept_wait", 32'(last_wait), 0);
    drain();
    check("reissue_rdata", 32'(rsp1_rdata), 60);

`ifdef RAM_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 5; i++) send(0, 1'b1, 10'(20 + i), 8'(i));
    for (int i = 0; i < 3; i++) send(1, 1'b1, 10'(40 + i), 8'(i));
    drain();
    check("grant_cnt0", 32'(grant_cnt0), 5);
    check("grant_cnt1", 32'(grant_cnt1), 3);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr", {grant_cnt0, grant_cnt1}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 1024x8 single-port ram block (`en`=1 write, `en`=0 read, synchronous read).
- Accepts one command at a time from either requester over a valid/ready handshake and grants access round-robin.
- Drives the ram's `en`/`address`/`datain`, captures `dataout` and returns read data to the granted requester.

Parameters:
- ADDR_W, 10, ram address width.
- DATA_W, 8, ram data width.
- RD_LAT, 1, ram read latency in clocks, range 1-4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  command address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  command accepted when valid&ready.
- rsp0_valid  out  1  one-cycle read-data strobe.
- rsp0_rdata  out  DATA_W  read data, held until next read response.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as requester 0.
- ram_en  out  1  to ram `en`.
- ram_address  out  ADDR_W  to ram `address`.
- ram_datain  out  DATA_W  to ram `datain`.
- ram_dataout  in  DATA_W  from ram `dataout`.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset is asynchronous. ram_en drops to 0 immediately. Any in-flight command is discarded with no rsp, and the requester reissues.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational and high only for the selected requester.
  - Selection: if one valid, that one. If both valid, the one not equal to last_grant.
  - On valid&ready, latch we/addr/wdata/id, update last_grant, go to ISSUE.
  - No valid: stay in IDLE, both ready low.
- ISSUE (1 cycle):
  - Registered outputs: ram_address=addr, ram_datain=wdata, ram_en=we.
  - Write: ram writes at the end of this cycle; next state IDLE.
  - Read: ram_en=0; next state WAIT.
- WAIT:
  - Counts RD_LAT cycles with ram_en=0 and ram_address held.
  - On the last WAIT cycle edge, capture ram_dataout into rspN_rdata of the latched id; go to RESP.
- RESP (1 cycle):
  - rspN_valid=1 for the latched id only.
  - Both ready low; next state IDLE.
- Timing, with acceptance in cycle T:
  - Write occupies the ram in T+1; the next acceptance is possible in T+2.
  - Read: rsp_valid in cycle T+2+RD_LAT; the next acceptance is possible in T+3+RD_LAT.
- Idle outputs:
  - ram_en is 0 outside ISSUE-write.
  - ram_address and ram_datain hold their last values.
- rspN_rdata holds its value between responses and is never touched by writes or by the other requester.
- Requester handshake:
  - Requester must hold its valid and command stable until ready.
  - A valid deasserted before acceptance is simply not served.
- No back-to-back grant to the same requester while the other is waiting. Fairness: maximum one other command between two grants.
- Address/data pass through unmodified. Full range 0..2^ADDR_W-1 is legal; no wrap logic needed.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each), incremented on each acceptance from that requester.
  - Counters saturate at 16'hFFFF and are cleared by rst.
  - Adds input cnt_clr (1 bit), a synchronous clear of both counters. If cnt_clr coincides with a grant, the count becomes 0.
- Undefined: those ports and counters do not exist; arbitration is identical.

Test Plan:
- Reset, then req0 write addr 800 data 50 -> req0_ready high in the accept cycle; ram_en=1, ram_address=800, ram_datain=50 exactly one cycle later; ram_en=0 after.
- req1 write addr 900 data 60, then req0 read 800 and req1 read 900 -> rsp0_valid pulse with rsp0_rdata=50 at T+3 (RD_LAT=1); rsp1_rdata=60 at the following response; no rsp on the other port.
- req0 and req1 both held valid with reads from reset -> grant order 0,1,0,1; each grant alternates; no starvation over 8 commands.
- Only req1 valid for 3 back-to-back writes -> all three granted consecutively, spaced 2 cycles apart.
- Assert rst during WAIT of a read to addr 900 -> ram_en=0, no rspN_valid, state IDLE; a reissued read after release returns 60.
- RAM_ARB_PERF_EN: 5 grants to req0, 3 to req1 -> grant_cnt0=5, grant_cnt1=3; cnt_clr pulse -> both 0.
